decode_regfile: RTL and testbench
=================================

# decode_regfile

Decode and write-back stage of the single-cycle Y86-64 CPU, sitting directly downstream of the fetch stage. It consumes `icode`, `rA` and `rB` from fetch and derives the register source and destination IDs. It holds the 15-entry × 64-bit program register file, supplying `valA`/`valB` combinationally and committing `valE`/`valM` on the clock edge at the end of the instruction.

## Interface
- `BYPASS`, default 0: 1 makes a read of a register being written this cycle return the write data; 0 returns the stored value.
- `RSP_INIT`, default 64'h0000_0000_0000_0400: reset value of `%rsp` (register 4), the top of the 1 KiB memory.
- `clk_i`  in  1  clock; all register writes on rising edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `icode_i`  in  4  instruction code from fetch.
- `rA_i`  in  4  register field A from fetch; 4'hF means none.
- `rB_i`  in  4  register field B from fetch; 4'hF means none.
- `cnd_i`  in  1  condition result from execute; gates the `cmovXX` write.
- `valE_i`  in  64  ALU result for the E write port.
- `valM_i`  in  64  memory read data for the M write port.
- `wb_en_i`  in  1  commit enable; 0 when stat is not AOK (halt, invalid instruction, imem/dmem error).
- `srcA_o`  out  4  register ID read on port A.
- `srcB_o`  out  4  register ID read on port B.
- `dstE_o`  out  4  register ID written from `valE_i`.
- `dstM_o`  out  4  register ID written from `valM_i`.
- `valA_o`  out  64  register[srcA], or 0 if srcA = F.
- `valB_o`  out  64  register[srcB], or 0 if srcB = F.

## Operation
- icode encodings: HALT 0, NOP 1, CMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RSP = 4, RNONE = F.
- srcA:
  - rA for CMOVQ, RMMOVQ, OPQ, PUSHQ.
  - RSP for POPQ, RET.
  - F otherwise.
- srcB:
  - rB for RMMOVQ, MRMOVQ, OPQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - F otherwise.
- dstE:
  - rB for IRMOVQ and OPQ.
  - rB for CMOVQ only when `cnd_i` = 1; F when `cnd_i` = 0.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - F otherwise.
- dstM:
  - rA for MRMOVQ, POPQ.
  - F otherwise.
- Unknown icodes (C–F) produce srcA = srcB = dstE = dstM = F.
- Storage: registers 0–14, 64 bits each. No storage exists for ID F. Writes to F are discarded; reads of F return 0.
- Write rule, at the rising edge with `rst_n_i` high and `wb_en_i` = 1:
  - if dstE ≠ F, write `valE_i` to reg[dstE];
  - if dstM ≠ F, write `valM_i` to reg[dstM];
  - if dstE = dstM ≠ F, `valM_i` wins (`popq %rsp` semantics).
- `wb_en_i` = 0: no register changes. Decode outputs still track the inputs.
- Reads are combinational from the array.
- BYPASS = 1 forwarding, applied only when `wb_en_i` = 1:
  - srcX = dstM → `valM_i`;
  - else srcX = dstE → `valE_i`;
  - else the stored value.
- BYPASS = 0: reads always return the stored value.

## Timing
- All decode outputs are combinational from the inputs; zero-cycle latency.
- A write becomes visible on `valA_o`/`valB_o` after the next rising edge (same cycle if BYPASS = 1).
- Reset (`rst_n_i` low), asynchronously and immediately:
  - all registers cleared to 0, except reg 4 = RSP_INIT;
  - the clear holds while reset is low, and clock edges perform no writes.
- Reset deasserting coincident with a rising edge: that edge performs no write.
- Reset asserted mid-instruction discards any pending commit.
- Outputs during reset:
  - `valA_o`/`valB_o` reflect the reset contents;
  - `src`/`dst` outputs remain a combinational decode of the inputs.
- No X propagation: reads of F and unknown icodes yield defined 0/F values.

## Test plan
- Reset, then icode = 6, rA = 4, rB = 0 → valA = 64'h400, valB = 0; srcA = 4, srcB = 0, dstE = 0, dstM = F.
- IRMOVQ (icode 3, rA = F, rB = 8), valE = 8, wb_en = 1, one edge; then OPQ with rA = 8, rB = 3 → valA = 8, dstE = 3.
- CMOVQ rA = 1, rB = 2 with cnd = 0 → dstE = F and reg 2 unchanged after edge; with cnd = 1 and valE = 5 → reg 2 = 5.
- POPQ rA = 4: valE = 64'h408, valM = 64'hAA, one edge → reg 4 = 64'hAA (M beats E).
- wb_en = 0 with IRMOVQ rB = 1, valE = 64'h77 → reg 1 stays 0. BYPASS = 1: srcA = dstE = 5, valE = 64'h99 → valA = 64'h99 before the edge.
- Write reg 7 = 64'h1234, assert `rst_n_i` low between edges → reg 7 reads 0 and reg 4 reads RSP_INIT immediately; edges while low cause no writes.

Source files
------------

// File: rtl/decode_regfile.sv
// Y86-64 decode / write-back stage: register ID decode plus the
// 15 x 64-bit program register file with dual write ports.
module decode_regfile #(
   parameter bit          BYPASS   = 1'b0,
   parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0400
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  icode_i,
   input  logic [3:0]  rA_i,
   input  logic [3:0]  rB_i,
   input  logic        cnd_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valM_i,
   input  logic        wb_en_i,
   output logic [3:0]  srcA_o,
   output logic [3:0]  srcB_o,
   output logic [3:0]  dstE_o,
   output logic [3:0]  dstM_o,
   output logic [63:0] valA_o,
   output logic [63:0] valB_o
);

   localparam logic [3:0] I_CMOVQ  = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] RSP      = 4'h4;
   localparam logic [3:0] RNONE    = 4'hF;

   logic [3:0]  srca, srcb, dste, dstm;
   logic [63:0] rf_q [15];
   logic [63:0] rf_d [15];
   logic        fwd_en;

   always_comb begin
      srca = RNONE;
      srcb = RNONE;
      dste = RNONE;
      dstm = RNONE;
      unique case (icode_i)
         I_CMOVQ: begin
            srca = rA_i;
            dste = cnd_i ? rB_i : RNONE;
         end
         I_IRMOVQ: dste = rB_i;
         I_RMMOVQ: begin
            srca = rA_i;
            srcb = rB_i;
         end
         I_MRMOVQ: begin
            srcb = rB_i;
            dstm = rA_i;
         end
         I_OPQ: begin
            srca = rA_i;
            srcb = rB_i;
            dste = rB_i;
         end
         I_CALL: begin
            srcb = RSP;
            dste = RSP;
         end
         I_RET: begin
            srca = RSP;
            srcb = RSP;
            dste = RSP;
         end
         I_PUSHQ: begin
            srca = rA_i;
            srcb = RSP;
            dste = RSP;
         end
         I_POPQ: begin
            srca = RSP;
            srcb = RSP;
            dste = RSP;
            dstm = rA_i;
         end
         default: ;
      endcase
   end

   assign srcA_o = srca;
   assign srcB_o = srcb;
   assign dstE_o = dste;
   assign dstM_o = dstm;

   // M port applied last so it wins when both target the same register
   always_comb begin
      rf_d = rf_q;
      if (wb_en_i) begin
         if (dste != RNONE) rf_d[dste] = valE_i;
         if (dstm != RNONE) rf_d[dstm] = valM_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 15; i++)
            rf_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end else begin
         rf_q <= rf_d;
      end
   end

   assign fwd_en = BYPASS && wb_en_i && rst_n_i;

   always_comb begin
      valA_o = '0;
      valB_o = '0;
      if (srca != RNONE) begin
         valA_o = rf_q[srca];
         if (fwd_en && srca == dstm)      valA_o = valM_i;
         else if (fwd_en && srca == dste) valA_o = valE_i;
      end
      if (srcb != RNONE) begin
         valB_o = rf_q[srcb];
         if (fwd_en && srcb == dstm)      valB_o = valM_i;
         else if (fwd_en && srcb == dste) valB_o = valE_i;
      end
   end

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: one instance without and one
// with bypass, both checked against an architectural register model.
module tb_decode_regfile;

   localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  icode = 4'h0, ra = 4'hF, rb = 4'hF;
   logic        cnd = 1'b0, wb = 1'b0;
   logic [63:0] vale = '0, valm = '0;

   logic [3:0]  sa0, sb0, de0, dm0, sa1, sb1, de1, dm1;
   logic [63:0] a0, b0, a1, b1;

   always #5 clk = ~clk;

   decode_regfile #(.BYPASS(1'b0), .RSP_INIT(RSP_INIT)) u_nb (
      .clk_i(clk), .rst_n_i(rst_n), .icode_i(icode), .rA_i(ra),
      .rB_i(rb), .cnd_i(cnd), .valE_i(vale), .valM_i(valm),
      .wb_en_i(wb), .srcA_o(sa0), .srcB_o(sb0), .dstE_o(de0),
      .dstM_o(dm0), .valA_o(a0), .valB_o(b0));

   decode_regfile #(.BYPASS(1'b1), .RSP_INIT(RSP_INIT)) u_bp (
      .clk_i(clk), .rst_n_i(rst_n), .icode_i(icode), .rA_i(ra),
      .rB_i(rb), .cnd_i(cnd), .valE_i(vale), .valM_i(valm),
      .wb_en_i(wb), .srcA_o(sa1), .srcB_o(sb1), .dstE_o(de1),
      .dstM_o(dm1), .valA_o(a1), .valB_o(b1));

   typedef struct {
      logic [3:0]  sa, sb, de, dm;
      logic [63:0] a0, b0, a1, b1;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] m [15];
   int          n_pass = 0;
   int          n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic void ref_dec(input logic [3:0] ic, r_a, r_b,
                                   input logic c,
                                   output logic [3:0] s_a, s_b, d_e, d_m);
      s_a = 4'hF; s_b = 4'hF; d_e = 4'hF; d_m = 4'hF;
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) s_a = r_a;
      else if (ic inside {4'h9, 4'hB})        s_a = 4'h4;
      if (ic inside {4'h4, 4'h5, 4'h6})             s_b = r_b;
      else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})  s_b = 4'h4;
      if (ic inside {4'h3, 4'h6})                   d_e = r_b;
      else if (ic == 4'h2)                          d_e = c ? r_b : 4'hF;
      else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})  d_e = 4'h4;
      if (ic inside {4'h5, 4'hB}) d_m = r_a;
   endfunction

   function automatic logic [63:0] stored(input logic [3:0] id);
      return (id == 4'hF) ? 64'h0 : m[id];
   endfunction

   function automatic logic [63:0] fwd(input logic [3:0] id, d_e, d_m);
      if (id != 4'hF && wb && rst_n) begin
         if (id == d_m) return valm;
         if (id == d_e) return vale;
      end
      return stored(id);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 15; i++) m[i] = 64'h0;
      m[4] = RSP_INIT;
   endfunction

   // one instruction: commit the one held over the last edge, then apply new
   task automatic step(input logic r, input logic [3:0] ic, r_a, r_b,
                       input logic c, input logic [63:0] e, mm,
                       input logic w);
      exp_t x;
      logic [3:0] s_a, s_b, d_e, d_m;
      @(posedge clk);
      #1;
      if (rst_n && wb) begin
         ref_dec(icode, ra, rb, cnd, s_a, s_b, d_e, d_m);
         if (d_e != 4'hF) m[d_e] = vale;
         if (d_m != 4'hF) m[d_m] = valm;
      end
      rst_n = r; icode = ic; ra = r_a; rb = r_b;
      cnd = c; vale = e; valm = mm; wb = w;
      if (!r) model_reset();
      ref_dec(ic, r_a, r_b, c, s_a, s_b, d_e, d_m);
      x.sa = s_a; x.sb = s_b; x.de = d_e; x.dm = d_m;
      x.a0 = stored(s_a); x.b0 = stored(s_b);
      x.a1 = fwd(s_a, d_e, d_m); x.b1 = fwd(s_b, d_e, d_m);
      sbq.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("srcA", {60'h0, sa0}, {60'h0, x.sa});
            chk("srcB", {60'h0, sb0}, {60'h0, x.sb});
            chk("dstE", {60'h0, de0}, {60'h0, x.de});
            chk("dstM", {60'h0, dm0}, {60'h0, x.dm});
            chk("dstE_bp", {60'h0, de1}, {60'h0, x.de});
            chk("valA", a0, x.a0);
            chk("valB", b0, x.b0);
            chk("valA_bp", a1, x.a1);
            chk("valB_bp", b1, x.b1);
         end
      end
   end

   initial begin : stim
      model_reset();
      step(0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0);
      step(1, 4'h6, 4'h4, 4'h0, 0, 0, 0, 0);
      // irmovq then read back
      step(1, 4'h3, 4'hF, 4'h8, 0, 64'h8, 0, 1);
      step(1, 4'h6, 4'h8, 4'h3, 0, 0, 0, 0);
      // cmovq not taken, then taken
      step(1, 4'h2, 4'h1, 4'h2, 0, 64'h55, 0, 1);
      step(1, 4'h6, 4'h2, 4'h2, 0, 0, 0, 0);
      step(1, 4'h2, 4'h1, 4'h2, 1, 64'h5, 0, 1);
      step(1, 4'h6, 4'h2, 4'h2, 0, 0, 0, 0);
      // popq %rsp: M beats E
      step(1, 4'hB, 4'h4, 4'hF, 0, 64'h408, 64'hAA, 1);
      step(1, 4'h6, 4'h4, 4'h4, 0, 0, 0, 0);
      // suppressed commit
      step(1, 4'h3, 4'hF, 4'h1, 0, 64'h77, 0, 0);
      step(1, 4'h6, 4'h1, 4'h1, 0, 0, 0, 0);
      // same-cycle read of a register being written
      step(1, 4'h6, 4'h5, 4'h5, 0, 64'h99, 0, 1);
      step(1, 4'hB, 4'h6, 4'hF, 0, 64'h11, 64'h22, 1);
      step(1, 4'h6, 4'h5, 4'h6, 0, 0, 0, 0);
      // reset between edges clears, and held reset blocks writes
      step(1, 4'h3, 4'hF, 4'h7, 0, 64'h1234, 0, 1);
      step(0, 4'h6, 4'h7, 4'h4, 0, 64'hDEAD, 0, 1);
      step(0, 4'h3, 4'hF, 4'h7, 0, 64'hBEEF, 0, 1);
      step(1, 4'h6, 4'h7, 4'h4, 0, 0, 0, 0);
      // unknown icodes and none register reads
      step(1, 4'hC, 4'h1, 4'h2, 1, 64'h3, 64'h4, 1);
      step(1, 4'hF, 4'hF, 4'hF, 1, 64'h3, 64'h4, 1);
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 40) != 0),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 4) != 0));
      end
      repeat (3) @(posedge clk);
      n_total++;
      if (sbq.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
